// File: rtl/uart_rx_clockset.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM, one-cycle
// rx_valid / frame_err pulses. state_dbg_o exposes the FSM state for checkers.
module uart_rx_clockset #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy,
  output logic [2:0] state_dbg_o
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             sync1_q, rxd_s_q;

  // Synchronizer resets to the idle-high line level so reset release never
  // looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      rxd_s_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      rxd_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxd_s_q) begin
          state_d = START;
          bit_d   = '0;
        end
      end
      START: begin
        // A start bit that is no longer low at its midpoint is a glitch.
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          state_d = rxd_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          shift_d = {rxd_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          if (rxd_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rxd_s_q) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_err   = ferr_q;
  assign busy        = (state_q != IDLE);
  assign state_dbg_o = state_q;

endmodule

// File: doc/uart_rx_clockset.md
UART_RX_CLOCKSET -- requirements
Module: uart_rx_clockset

Interface
REQ-001 Parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate.
REQ-003 Derived constant: CLKS_PER_BIT = CLK_HZ/BAUD (integer division, 434 at defaults); HALF_BIT = CLKS_PER_BIT/2 (217 at defaults).
REQ-004 clk  input  1  system clock; all logic on the rising edge; single clock domain.
REQ-005 rst  input  1  reset, asynchronous and active-low.
REQ-006 rxd  input  1  asynchronous serial line; idle high; 8N1 frames, LSB first.
REQ-007 rx_data  output  8  last correctly framed byte; registered.
REQ-008 rx_valid  output  1  one-cycle pulse when rx_data is updated.
REQ-009 frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 rxd SHALL pass through a two-flop synchronizer; all FSM decisions use the synchronized value (rxd_s) only.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-013 IDLE: rxd_s = 0 -> START, bit counter cleared; otherwise stay.
REQ-014 START: after HALF_BIT cycles, sample rxd_s; 0 -> DATA with the cycle counter cleared; 1 -> IDLE (glitch reject, no output pulse).
REQ-015 DATA: every CLKS_PER_BIT cycles, sample rxd_s into the shift register, LSB first; after the 8th sample -> STOP.
REQ-016 STOP: after CLKS_PER_BIT cycles, sample rxd_s; 1 -> load rx_data, pulse rx_valid, go to IDLE; 0 -> pulse frame_err, leave rx_data unchanged, go to WAIT_HIGH.
REQ-017 WAIT_HIGH: stay until rxd_s = 1, then IDLE; this prevents a held-low (break) line from retriggering a start.
REQ-018 The cycle counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL reset to 0 on every state transition; the bit counter is 3 bits and counts 0..7.
REQ-019 rx_valid and frame_err SHALL never be high in the same cycle, and each SHALL be high for exactly one clk cycle per frame.
REQ-020 rx_data SHALL hold its value until the next valid frame completes; no consumer handshake exists, and a new byte overwrites the old one.
REQ-021 A start edge arriving in the same cycle as the return to IDLE from STOP SHALL be detected on the next IDLE cycle (back-to-back frames are supported with no gap beyond the stop bit).
REQ-022 Latency from the rxd pin falling edge to rx_valid high SHALL be 2 + HALF_BIT + 9*CLKS_PER_BIT cycles, +/-2 (4125 +/-2 at defaults).

Reset
REQ-023 While rst = 0, the FSM SHALL be in IDLE, counters 0, shift register 0x00, rx_data = 0x00, rx_valid = 0, frame_err = 0, busy = 0, and synchronizer flops = 1.
REQ-024 Asserting reset mid-frame SHALL abort the frame immediately with no output pulse; after release, the block SHALL wait for a fresh falling edge.

Verification
REQ-025 Frame 0x5A at 115200 with defaults -> exactly one rx_valid pulse 4125 +/-2 cycles after the start edge, rx_data = 0x5A, frame_err stays 0.
REQ-026 rxd low for 100 cycles, then high -> busy pulses, no rx_valid and no frame_err, FSM back in IDLE before cycle 220.
REQ-027 Frame 0x33 with the stop bit driven low and rxd held low for 2000 more cycles -> one frame_err pulse, rx_data unchanged, no new start until rxd returns high.
REQ-028 Back-to-back frames 0x00 then 0xFF with no idle gap -> two rx_valid pulses 4340 +/-2 cycles apart, with rx_data 0x00 then 0xFF.
REQ-029 rst asserted during DATA bit 4 of 0xA5, then released, then frame 0x81 sent -> no pulse for 0xA5, one rx_valid with rx_data = 0x81.
REQ-030 Parameter override CLK_HZ = 1000000, BAUD = 100000 (CLKS_PER_BIT = 10), frame 0xC3 -> rx_data = 0xC3 with rx_valid 2 + 5 + 90 +/-2 cycles after the start edge.
